// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus RTU transmit path.
// The CRC helper is only referenced when MODBUS_TX_CRC_EN is defined.
package modbus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GAP,
    ST_RD,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    PH_DATA,
    PH_CRC_LO,
    PH_CRC_HI
  } tx_phase_t;

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'hA001;
  localparam int unsigned GAP_BITS_DEF = 35;

  // One byte of reflected CRC16/Modbus, LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {8'h00, din};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_modbus.sv
// Byte-serial CRC16/Modbus accumulator, one byte per crc_en cycle.
// Instantiated by the transmit sequencer only when MODBUS_TX_CRC_EN is defined.
module crc16_modbus
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        crc_clr,
  input  logic        crc_en,
  input  logic [7:0]  crc_din,
  output logic [15:0] crc_out
);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc_out <= CRC_INIT;
    end else if (crc_clr) begin
      crc_out <= CRC_INIT;
    end else if (crc_en) begin
      crc_out <= crc16_step(crc_out, crc_din);
    end
  end

endmodule

// File: rtl/modbus_rtu_tx_frame.sv
// Modbus RTU transmit frame sequencer: silent-interval gate, buffer read, UART handshake.
// Define MODBUS_TX_CRC_EN to append a computed CRC16 after the payload.
module modbus_rtu_tx_frame
  import modbus_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned GAP_BITS  = GAP_BITS_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  input  logic       rx_done,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_en,
  input  logic       uart_tx_done,
  output logic       tx_busy,
  output logic       tx_frame_done
);

  localparam logic [15:0] BPS_PARAM = 16'(CLK_FREQ / BAUD_RATE);
  localparam logic [5:0]  GAP_CNT   = 6'(GAP_BITS);

  logic [15:0] baud_cnt;
  logic [5:0]  bit_cnt;
  logic        gap_ok;
  logic        timer_clr;

  assign timer_clr = rx_done | uart_tx_done;
  assign gap_ok    = (bit_cnt == GAP_CNT);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (timer_clr) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (baud_cnt == BPS_PARAM - 16'd1) begin
      baud_cnt <= '0;
      if (!gap_ok) bit_cnt <= bit_cnt + 6'd1;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  tx_state_t  state;
  logic [7:0] len;
  logic [7:0] idx;
  logic [7:0] idx_nxt;
  logic       accept;

  assign idx_nxt = idx + 8'd1;
  // tx_busy is low exactly in IDLE and DONE, so both may accept a new frame.
  assign accept  = tx_start && (tx_len != 8'd0) && (state == ST_IDLE || state == ST_DONE);

`ifdef MODBUS_TX_CRC_EN
  tx_phase_t   phase;
  logic [15:0] crc_val;

  crc16_modbus u_crc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .crc_clr  (accept),
    .crc_en   (state == ST_LATCH),
    .crc_din  (rd_data),
    .crc_out  (crc_val)
  );
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      len           <= '0;
      idx           <= '0;
      rd_addr       <= '0;
      uart_tx_data  <= '0;
      uart_tx_en    <= 1'b0;
      tx_busy       <= 1'b0;
      tx_frame_done <= 1'b0;
`ifdef MODBUS_TX_CRC_EN
      phase         <= PH_DATA;
`endif
    end else begin
      uart_tx_en    <= 1'b0;
      tx_frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            len     <= tx_len;
            idx     <= '0;
            tx_busy <= 1'b1;
            state   <= ST_GAP;
`ifdef MODBUS_TX_CRC_EN
            phase   <= PH_DATA;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_ok && !rx_done) begin
            rd_addr <= idx;
            state   <= ST_RD;
          end
        end
        ST_RD:    state <= ST_LATCH;
        ST_LATCH: begin
          uart_tx_data <= rd_data;
          uart_tx_en   <= 1'b1;
          state        <= ST_SEND;
        end
        ST_SEND:  state <= ST_WAIT;
        ST_WAIT: begin
          if (uart_tx_done) begin
`ifdef MODBUS_TX_CRC_EN
            case (phase)
              PH_DATA: begin
                idx <= idx_nxt;
                if (idx_nxt < len) begin
                  rd_addr <= idx_nxt;
                  state   <= ST_RD;
                end else begin
                  phase <= PH_CRC_LO;
                  state <= ST_CRC_LO;
                end
              end
              PH_CRC_LO: begin
                phase <= PH_CRC_HI;
                state <= ST_CRC_HI;
              end
              default: begin
                tx_busy       <= 1'b0;
                tx_frame_done <= 1'b1;
                state         <= ST_DONE;
              end
            endcase
`else
            idx <= idx_nxt;
            if (idx_nxt < len) begin
              rd_addr <= idx_nxt;
              state   <= ST_RD;
            end else begin
              tx_busy       <= 1'b0;
              tx_frame_done <= 1'b1;
              state         <= ST_DONE;
            end
`endif
          end
        end
`ifdef MODBUS_TX_CRC_EN
        ST_CRC_LO: begin
          uart_tx_data <= crc_val[7:0];
          uart_tx_en   <= 1'b1;
          state        <= ST_SEND;
        end
        ST_CRC_HI: begin
          uart_tx_data <= crc_val[15:8];
          uart_tx_en   <= 1'b1;
          state        <= ST_SEND;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_tx_frame.sv
// Self-checking bench for modbus_rtu_tx_frame: buffer RAM and UART responder models,
// reference frame builder with bitwise CRC16/Modbus when MODBUS_TX_CRC_EN is defined.
module tb_modbus_rtu_tx_frame;

  localparam int unsigned BPS      = 10;
  localparam int unsigned GAP_CLKS = 35 * BPS;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_len = '0;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic       rx_done = 1'b0;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en;
  logic       uart_tx_done = 1'b0;
  logic       tx_busy;
  logic       tx_frame_done;

  modbus_rtu_tx_frame #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .GAP_BITS  (35)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .tx_start      (tx_start),
    .tx_len        (tx_len),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rx_done       (rx_done),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_done  (uart_tx_done),
    .tx_busy       (tx_busy),
    .tx_frame_done (tx_frame_done)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [7:0] mem [256];
  always @(posedge clk_in) rd_data <= mem[rd_addr];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int unsigned obs, input int unsigned lo,
                           input int unsigned hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // UART responder: records each byte, answers with uart_tx_done after a random delay.
  logic [7:0]  byte_q[$];
  int unsigned en_q[$];
  int unsigned done_q[$];
  int unsigned fd_q[$];
  logic [7:0]  held;
  bit          pend = 0;
  bit          fixed_dly = 0;
  int unsigned dly = 0;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      uart_tx_done = 1'b0;
      pend = 0;
    end else begin
      uart_tx_done = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          check("uart_data_stable", uart_tx_data, held);
          uart_tx_done = 1'b1;
          pend = 0;
          done_q.push_back(cyc);
        end else begin
          dly--;
        end
      end
      if (uart_tx_en) begin
        check("busy_during_send", tx_busy, 1);
        byte_q.push_back(uart_tx_data);
        en_q.push_back(cyc);
        held = uart_tx_data;
        pend = 1;
        dly = fixed_dly ? 5 : $urandom_range(0, 5);
      end
      if (tx_frame_done) begin
        check("busy_low_at_done", tx_busy, 0);
        fd_q.push_back(cyc);
      end
    end
  end

  logic [7:0]  payload[$];
  int unsigned start_cyc;

  function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic fill(input int unsigned n);
    payload.delete();
    repeat (n) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clear_log();
    byte_q.delete(); en_q.delete(); done_q.delete(); fd_q.delete();
  endtask

  task automatic start_frame();
    clear_log();
    foreach (payload[i]) mem[i] = payload[i];
    @(negedge clk_in);
    tx_len = 8'(payload.size());
    tx_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk_in);
    tx_start = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int unsigned n;
    n = 0;
    while (fd_q.size() == 0 && n < 6000) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, ".frame_done_seen"}, fd_q.size() != 0, 1);
  endtask

  task automatic check_frame(input string tag, input bit lat);
    logic [7:0]  exp_q[$];
    logic [15:0] c;
    exp_q = payload;
`ifdef MODBUS_TX_CRC_EN
    c = crc_ref(payload);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
`else
    c = '0;
`endif
    check({tag, ".nbytes"}, byte_q.size(), exp_q.size());
    if (byte_q.size() == exp_q.size())
      foreach (exp_q[i]) check($sformatf("%s.byte%0d", tag, i), byte_q[i], exp_q[i]);
    if (lat && en_q.size() > 0) check({tag, ".first_en_latency"}, en_q[0] - start_cyc, 4);
    for (int i = 1; i < en_q.size(); i++)
      if (done_q.size() >= i)
        check($sformatf("%s.en_gap%0d", tag, i), en_q[i] - done_q[i-1],
              (i < payload.size()) ? 3 : 2);
    check({tag, ".frame_done_count"}, fd_q.size(), 1);
    if (fd_q.size() > 0 && done_q.size() > 0)
      check({tag, ".frame_done_timing"}, fd_q[0], done_q[$] + 1);
  endtask

  initial begin
    int unsigned r1, r2, rel, n, last_a;
    int unsigned lens [4];
    logic [7:0]  golden[$];

    // Reset values
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst.rd_addr", rd_addr, 0);
    check("rst.uart_tx_data", uart_tx_data, 0);
    check("rst.uart_tx_en", uart_tx_en, 0);
    check("rst.tx_busy", tx_busy, 0);
    check("rst.tx_frame_done", tx_frame_done, 0);
    rst_n_in = 1'b1;
    repeat (GAP_CLKS + 20) @(negedge clk_in);

    // Known vector, gap already satisfied
    payload = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
`ifndef MODBUS_TX_CRC_EN
    payload.push_back(8'h84);
    payload.push_back(8'h0A);
`endif
    golden = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    start_frame();
    wait_fd("vec");
    check_frame("vec", 1);
    if (byte_q.size() == golden.size())
      foreach (golden[i]) check($sformatf("vec.golden%0d", i), byte_q[i], golden[i]);
    repeat (12) @(negedge clk_in);
    check("vec.no_extra_done", fd_q.size(), 1);

    // tx_start 10 bit-times after rx_done
    fill(4);
    @(negedge clk_in); rx_done = 1'b1; r1 = cyc;
    @(negedge clk_in); rx_done = 1'b0;
    repeat (10 * BPS - 2) @(negedge clk_in);
    start_frame();
    wait_fd("rxgap");
    check_frame("rxgap", 0);
    if (en_q.size() > 0) check_rng("rxgap.first_en_after_rx", en_q[0] - r1, GAP_CLKS, GAP_CLKS + 8);

    // Second rx_done inside the gap restarts the wait
    fill(3);
    @(negedge clk_in); rx_done = 1'b1; r1 = cyc;
    @(negedge clk_in); rx_done = 1'b0;
    repeat (10 * BPS) @(negedge clk_in);
    start_frame();
    repeat (150) @(negedge clk_in);
    rx_done = 1'b1; r2 = cyc;
    @(negedge clk_in); rx_done = 1'b0;
    wait_fd("rxgap2");
    check_frame("rxgap2", 0);
    if (en_q.size() > 0) check_rng("rxgap2.first_en_after_rx2", en_q[0] - r2, GAP_CLKS, GAP_CLKS + 8);

    // Back-to-back frames
    repeat (GAP_CLKS + 20) @(negedge clk_in);
    fill(5);
    start_frame();
    wait_fd("b2b_a");
    check_frame("b2b_a", 1);
    last_a = (done_q.size() > 0) ? done_q[$] : cyc;
    fill(4);
    start_frame();
    wait_fd("b2b_b");
    check_frame("b2b_b", 0);
    if (en_q.size() > 0) check_rng("b2b.second_gap", en_q[0] - last_a, GAP_CLKS, GAP_CLKS + 8);

    // tx_start while busy is ignored
    repeat (GAP_CLKS + 20) @(negedge clk_in);
    fill(5);
    start_frame();
    n = 0;
    while (en_q.size() == 0 && n < 1000) begin @(negedge clk_in); n++; end
    tx_len = 8'd3; tx_start = 1'b1;
    @(negedge clk_in); tx_start = 1'b0;
    wait_fd("busy");
    check_frame("busy", 1);
    repeat (12) @(negedge clk_in);
    check("busy.no_extra_done", fd_q.size(), 1);

    // tx_len = 0 is ignored
    repeat (GAP_CLKS + 20) @(negedge clk_in);
    clear_log();
    tx_len = 8'd0; tx_start = 1'b1;
    @(negedge clk_in); tx_start = 1'b0;
    repeat (GAP_CLKS + 30) @(negedge clk_in);
    check("len0.tx_busy", tx_busy, 0);
    check("len0.no_bytes", en_q.size(), 0);
    check("len0.no_done", fd_q.size(), 0);

    // Reset during WAIT of byte 3, then a full frame after a fresh gap
    fill(6);
    fixed_dly = 1;
    start_frame();
    n = 0;
    while (en_q.size() < 3 && n < 1000) begin @(negedge clk_in); n++; end
    check("midrst.reached_byte3", en_q.size(), 3);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("midrst.rd_addr", rd_addr, 0);
    check("midrst.uart_tx_data", uart_tx_data, 0);
    check("midrst.uart_tx_en", uart_tx_en, 0);
    check("midrst.tx_busy", tx_busy, 0);
    check("midrst.tx_frame_done", tx_frame_done, 0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    rel = cyc;
    fixed_dly = 0;
    start_frame();
    wait_fd("postrst");
    check_frame("postrst", 0);
    if (en_q.size() > 0) check_rng("postrst.fresh_gap", en_q[0] - rel, GAP_CLKS, GAP_CLKS + 8);

    // Random payloads including both length extremes
    lens = '{1, 252, 0, 0};
    lens[2] = $urandom_range(2, 40);
    lens[3] = $urandom_range(2, 40);
    foreach (lens[k]) begin
      repeat (GAP_CLKS + 20) @(negedge clk_in);
      fill(lens[k]);
      start_frame();
      wait_fd($sformatf("rand%0d", k));
      check_frame($sformatf("rand%0d", k), 1);
    end

    repeat (5) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
